imem_boot_loader: RTL and testbench

//   Upstream of the processor: fills instruction memory from a byte stream before execution.

---
 rtl/imem_boot_loader.sv | 143 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: packs an MSB-first byte stream into 32-bit words, writes them to
// instruction memory from address 0, and holds the CPU until the requested word count lands.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic [31:0]           checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   word_cnt_q;
    logic [1:0]            byte_cnt_q;
    logic [31:0]           word_q;
    logic                  in_ready_q;
    logic                  imem_we_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [31:0]           imem_wdata_q;
    logic                  cpu_hold_q;
    logic                  load_done_q;
    logic [31:0]           checksum_q;

    logic [ADDR_WIDTH:0]   len_d;
    logic [ADDR_WIDTH:0]   word_cnt_d;
    logic [31:0]           word_d;
    logic                  accept;

    // in_ready_q is only ever high in LOAD, so it alone qualifies a byte transfer.
    assign accept = in_valid && in_ready_q;

    always_comb begin
        len_d      = (load_len > DEPTH) ? DEPTH : load_len;
        word_cnt_d = word_cnt_q + (ADDR_WIDTH + 1)'(1);
    end

    always_comb begin
        word_d = word_q;
        case (byte_cnt_q)
            2'd0:    word_d[31:24] = in_data;
            2'd1:    word_d[23:16] = in_data;
            2'd2:    word_d[15:8]  = in_data;
            default: word_d[7:0]   = in_data;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            checksum_q   <= '0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (load_start) begin
                        len_q       <= len_d;
                        checksum_q  <= '0;
                        imem_addr_q <= '0;
                        byte_cnt_q  <= '0;
                        word_cnt_q  <= '0;
                        word_q      <= '0;
                        if (len_d != '0) begin
                            state_q     <= LOAD;
                            in_ready_q  <= 1'b1;
                            cpu_hold_q  <= 1'b1;
                            load_done_q <= 1'b0;
                        end else begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            cpu_hold_q  <= 1'b0;
                            load_done_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        word_q     <= word_d;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        // Fourth byte completes the word: present it to memory next cycle.
                        if (byte_cnt_q == 2'd3) begin
                            state_q      <= WRITE;
                            in_ready_q   <= 1'b0;
                            imem_we_q    <= 1'b1;
                            imem_wdata_q <= word_d;
                        end
                    end
                end
                WRITE: begin
                    checksum_q  <= checksum_q ^ imem_wdata_q;
                    imem_addr_q <= imem_addr_q + ADDR_WIDTH'(1);
                    word_cnt_q  <= word_cnt_d;
                    if (word_cnt_d == len_q) begin
                        state_q     <= DONE;
                        cpu_hold_q  <= 1'b0;
                        load_done_q <= 1'b1;
                    end else begin
                        state_q    <= LOAD;
                        in_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed table, hand sequences for reset/ignored-start/full depth,
// and randomized loads checked against a word-list model built from the byte stream.
module tb_imem_boot_loader;

    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic [31:0]   checksum;

    always #5 clock = ~clock;

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .checksum   (checksum)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_acc = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            c;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];

    typedef struct {
        int          len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          mode;
        int          exp_writes;
        logic [31:0] exp_cks;
    } vec_t;

    vec_t vecs[4];

    always @(posedge clock) cyc <= cyc + 1;

    // Write capture and the hold/done exclusivity invariant, sampled mid-cycle.
    always @(negedge clock) begin
        if (imem_we === 1'b1) wr_q.push_back('{imem_addr, imem_wdata, cyc});
        checks++;
        if (cpu_hold === 1'b1 && load_done === 1'b1) begin
            errors++;
            $display("FAIL hold_and_done: cpu_hold=%b load_done=%b expected not both 1 at cycle %0d",
                     cpu_hold, load_done, cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        tx_q.push_back(w[31:24]);
        tx_q.push_back(w[23:16]);
        tx_q.push_back(w[15:8]);
        tx_q.push_back(w[7:0]);
    endtask

    task automatic pulse_start(input int len);
        @(negedge clock);
        wr_q.delete();
        load_start = 1'b1;
        load_len   = len[AW:0];
        @(negedge clock);
        load_start = 1'b0;
    endtask

    // mode 0: full rate, 1: valid every other cycle, 2: random gaps
    task automatic send_bytes(input int mode, input int max_bytes);
        int sent;
        int n;
        int budget;
        sent   = 0;
        n      = 0;
        budget = 12 * max_bytes + 40;
        while (sent < max_bytes && tx_q.size() > 0 && n < budget) begin
            @(negedge clock);
            n++;
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = cyc[0];
                default: in_valid = ($urandom_range(0, 99) < 60);
            endcase
            in_data = tx_q[0];
            if (in_valid && in_ready) begin
                void'(tx_q.pop_front());
                sent++;
                last_acc = cyc + 1;
            end
        end
        check("bytes_accepted", sent, max_bytes);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        int n;
        n = 0;
        while (load_done !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        dc = cyc;
        check("done_reached", load_done, 1);
    endtask

    initial begin
        int          dc;
        int          bad;
        int          len;
        int          mode;
        logic [31:0] cks;
        logic [31:0] w;
        logic [31:0] exp_w[$];

        reset      = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        in_valid   = 1'b0;
        in_data    = '0;

        vecs[0] = '{2, 32'h8C010004, 32'hAC020008, 0, 2, 32'h2003000C};
        vecs[1] = '{0, 32'h0,        32'h0,        0, 0, 32'h0};
        vecs[2] = '{1, 32'hDEADBEEF, 32'h0,        1, 1, 32'hDEADBEEF};
        vecs[3] = '{2, 32'h12345678, 32'h12345678, 2, 2, 32'h0};

        // Reset values
        repeat (2) @(negedge clock);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_load_done", load_done, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_checksum", checksum, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_cpu_hold", cpu_hold, 1);
        check("idle_in_ready", in_ready, 0);

        // Directed table
        for (int i = 0; i < 4; i++) begin
            tx_q.delete();
            pulse_start(vecs[i].len);
            if (vecs[i].len == 0) begin
                check("len0_done_next", load_done, 1);
                check("len0_hold", cpu_hold, 0);
            end else begin
                check("start_hold", cpu_hold, 1);
                check("start_ready", in_ready, 1);
            end
            if (vecs[i].exp_writes >= 1) push_word(vecs[i].w0);
            if (vecs[i].exp_writes >= 2) push_word(vecs[i].w1);
            if (vecs[i].exp_writes > 0) begin
                send_bytes(vecs[i].mode, 4 * vecs[i].exp_writes);
                wait_done(40, dc);
                if (wr_q.size() > 0) check("we_latency", wr_q[wr_q.size()-1].c, last_acc);
                check("done_latency", dc, last_acc + 1);
            end else begin
                repeat (3) @(negedge clock);
            end
            check("n_writes", wr_q.size(), vecs[i].exp_writes);
            for (int j = 0; j < wr_q.size() && j < 2; j++) begin
                check("wr_addr", wr_q[j].addr, j);
                check("wr_data", wr_q[j].data, (j == 0) ? vecs[i].w0 : vecs[i].w1);
            end
            check("checksum", checksum, vecs[i].exp_cks);
            check("done_hold", cpu_hold, 0);
            check("done_ready", in_ready, 0);
            $display("vector %0d: len=%0d writes=%0d checksum=%h", i, vecs[i].len, wr_q.size(), checksum);
        end

        // load_start during LOAD must be ignored
        tx_q.delete();
        pulse_start(1);
        push_word(32'hA1B2C3D4);
        send_bytes(0, 2);
        pulse_start(3);
        send_bytes(0, 2);
        wait_done(40, dc);
        check("ign_n_writes", wr_q.size(), 1);
        if (wr_q.size() > 0) check("ign_data", wr_q[0].data, 32'hA1B2C3D4);
        check("ign_checksum", checksum, 32'hA1B2C3D4);
        $display("ignored-start sequence: writes=%0d", wr_q.size());

        // Randomized loads vs word-list model
        for (int r = 0; r < 15; r++) begin
            tx_q.delete();
            exp_w.delete();
            len  = $urandom_range(1, 9);
            mode = $urandom_range(0, 2);
            cks  = '0;
            for (int k = 0; k < len; k++) begin
                logic [31:0] b0, b1, b2, b3;
                b0 = $urandom_range(0, 255);
                b1 = $urandom_range(0, 255);
                b2 = $urandom_range(0, 255);
                b3 = $urandom_range(0, 255);
                w = b0 * 32'd16777216 + b1 * 32'd65536 + b2 * 32'd256 + b3;
                exp_w.push_back(w);
                cks = cks ^ w;
                tx_q.push_back(b0[7:0]);
                tx_q.push_back(b1[7:0]);
                tx_q.push_back(b2[7:0]);
                tx_q.push_back(b3[7:0]);
            end
            pulse_start(len);
            send_bytes(mode, 4 * len);
            wait_done(40, dc);
            check("rnd_n_writes", wr_q.size(), len);
            bad = 0;
            for (int j = 0; j < wr_q.size() && j < len; j++)
                if (wr_q[j].addr !== j[AW-1:0] || wr_q[j].data !== exp_w[j]) bad++;
            check("rnd_bad_entries", bad, 0);
            check("rnd_checksum", checksum, cks);
            check("rnd_done_latency", dc, last_acc + 1);
            $display("random load %0d: len=%0d mode=%0d writes=%0d checksum=%h", r, len, mode, wr_q.size(), checksum);
        end

        // Reset after 6 of 8 bytes
        tx_q.delete();
        pulse_start(2);
        push_word(32'h0BADF00D);
        push_word(32'h55AA1234);
        send_bytes(0, 6);
        reset = 1'b1;
        #1;
        check("mid_rst_hold", cpu_hold, 1);
        check("mid_rst_done", load_done, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_we", imem_we, 0);
        check("mid_rst_checksum", checksum, 0);
        check("mid_rst_addr", imem_addr, 0);
        @(negedge clock);
        reset = 1'b0;
        tx_q.delete();
        repeat (10) @(negedge clock);
        check("mid_rst_n_writes", wr_q.size(), 1);
        if (wr_q.size() > 0) check("mid_rst_wr0", wr_q[0].data, 32'h0BADF00D);
        check("mid_rst_idle_done", load_done, 0);
        $display("mid-load reset: writes=%0d", wr_q.size());

        // Full depth: clamp of an oversize length, starting from DONE
        pulse_start(0);
        check("pre_full_done", load_done, 1);
        tx_q.delete();
        exp_w.delete();
        cks = '0;
        for (int k = 0; k < 256; k++) begin
            w = $urandom;
            exp_w.push_back(w);
            cks = cks ^ w;
            push_word(w);
        end
        pulse_start(261);
        check("full_hold", cpu_hold, 1);
        check("full_not_done", load_done, 0);
        send_bytes(0, 1024);
        wait_done(40, dc);
        check("full_n_writes", wr_q.size(), 256);
        bad = 0;
        for (int j = 0; j < wr_q.size() && j < 256; j++)
            if (wr_q[j].addr !== j[AW-1:0] || wr_q[j].data !== exp_w[j]) bad++;
        check("full_bad_entries", bad, 0);
        check("full_checksum", checksum, cks);
        check("full_addr_wrap", imem_addr, 0);
        $display("full-depth load: writes=%0d checksum=%h", wr_q.size(), checksum);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
